deserializer: RTL and testbench
===============================

// Module: deserializer
// PURPOSE
//   Receive side of the framed byte link: hunts for HEADER, collects NUM_CHANNELS
//   data bytes, checks FOOTER, then presents the whole frame as one parallel word.
//   Sits downstream of the framing serializer (AA, 16 data bytes, FF).
//   Good frames update dout with a one-cycle dout_valid; malformed frames pulse frame_err.
// PARAMETERS
//   HEADER         8'hAA  start-of-frame byte
//   FOOTER         8'hFF  end-of-frame byte
//   NUM_CHANNELS   16     data bytes per frame (>=1, <=64)
//   TIMEOUT_CYCLES 64     max consecutive idle cycles mid-frame (DESER_TIMEOUT_EN only)
// PORTS
//   clk         in   1                 single clock, rising edge
//   rst         in   1                 asynchronous reset, active-high
//   din         in   8                 incoming byte
//   din_valid   in   1                 din is sampled this cycle
//   dout        out  8*NUM_CHANNELS    last good frame; channel k at dout[8k+7:8k]
//   dout_valid  out  1                 one-cycle pulse: dout updated
//   frame_err   out  1                 one-cycle pulse: frame discarded
//   busy        out  1                 high when state != IDLE
// BEHAVIOUR
//   - Reset (async, active-high): state=IDLE, cnt=0, buffer=0, dout=0,
//     dout_valid=0, frame_err=0. Reset mid-frame discards the partial frame silently.
//   - Bytes are consumed only on cycles with din_valid=1. Gaps are legal anywhere.
//   - FSM states and transitions:
//     IDLE: din_valid && din==HEADER -> RECV_DATA, cnt<=0. Other bytes are
//       dropped with no error, including FOOTER.
//     RECV_DATA: din_valid -> buffer[cnt]<=din, cnt<=cnt+1. On the write with
//       cnt==NUM_CHANNELS-1 -> CHECK_FOOTER. Bytes equal to HEADER or FOOTER are
//       plain data here; there is no resync.
//     CHECK_FOOTER: din_valid && din==FOOTER -> dout<=buffer, dout_valid<=1, go IDLE.
//       din_valid && din!=FOOTER -> frame_err<=1, go IDLE, dout unchanged.
//       The wrong byte is not re-examined as a HEADER.
//   - Latency: dout_valid/frame_err rise on the clock edge that samples the footer
//     byte (visible the cycle after it is presented). Both last exactly one cycle.
//     They are never high together.
//   - Back-to-back frames: a HEADER on the cycle right after the footer is accepted.
//     Zero-gap streams are therefore sustained.
//   - dout holds its value between good frames. The buffer is overwritten byte by byte.
//   - cnt is 6 bits; the compare is exact, so cnt never wraps.
//   - busy = (state != IDLE), combinational from the state register.
// CONFIGURATION
//   DESER_TIMEOUT_EN defined:
//     - A 16-bit gap counter runs in RECV_DATA/CHECK_FOOTER. It clears on
//       din_valid and on entering IDLE, and increments otherwise.
//     - When it reaches TIMEOUT_CYCLES: frame_err pulse, go IDLE, partial discarded.
//     - A din_valid on the expiry cycle is still processed normally; the timeout
//       does not fire.
//   DESER_TIMEOUT_EN undefined:
//     - No gap counter. The FSM waits indefinitely mid-frame; frame_err arises
//       only from a bad footer.
// TESTING
//   1. AA,00..0F,FF contiguous -> dout_valid 1 cycle after FF, dout[7:0]=00,
//      dout[127:120]=0F, frame_err=0.
//   2. Frame with bytes 11..20 and random din_valid gaps (1-10 cycles) -> same
//      dout_valid timing relative to FF; dout holds 11..20.
//   3. AA,16 data bytes,55 -> frame_err pulse, dout keeps the previous frame,
//      then a following AA..FF frame is accepted.
//   4. Garbage 12,FF,34 then AA,AA x16,FF -> garbage ignored; dout = all AA.
//   5. Two frames with zero gap (FF then AA next cycle) -> two dout_valid pulses
//      exactly 18 cycles apart.
//   6. rst asserted after 8 data bytes, then a full frame -> no pulse from the
//      partial frame, good frame decoded. With DESER_TIMEOUT_EN: stall 64 cycles
//      mid-frame -> frame_err, busy=0.

Source files
------------

// File: rtl/deserializer.sv
// deserializer: receive side of the framed byte link.
// Hunts for HEADER, collects NUM_CHANNELS data bytes and checks FOOTER.
// A good frame is presented on dout with a one-cycle dout_valid pulse.
// A frame with a wrong footer is dropped with a one-cycle frame_err pulse.
// Optional feature: define DESER_TIMEOUT_EN to abort a frame that stalls
// for TIMEOUT_CYCLES consecutive idle cycles mid-frame.
module deserializer #(
  parameter logic [7:0] HEADER         = 8'hAA,
  parameter logic [7:0] FOOTER         = 8'hFF,
  parameter int         NUM_CHANNELS   = 16,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                din,
  input  logic                      din_valid,
  output logic [8*NUM_CHANNELS-1:0] dout,
  output logic                      dout_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int         DATA_W   = 8;
  localparam int         FRAME_W  = DATA_W * NUM_CHANNELS;
  localparam logic [5:0] LAST_IDX = 6'(NUM_CHANNELS - 1);
  localparam logic       CFG_OK   = (NUM_CHANNELS >= 1) && (NUM_CHANNELS <= 64) &&
                                    (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535);

  // An out-of-range configuration elaborates this empty named block, which
  // makes the mistake visible in the instance hierarchy.
  if (!CFG_OK) begin : g_cfg_out_of_range
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    RECV_DATA    = 2'd1,
    CHECK_FOOTER = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [5:0]           cnt;
  logic [5:0]           cnt_nxt;
  logic [FRAME_W-1:0]   buffer;
  logic                 buf_we;
  logic                 dout_ld;
  logic                 dout_valid_nxt;
  logic                 frame_err_nxt;
  logic                 timeout_hit;

`ifdef DESER_TIMEOUT_EN
  localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] gap_cnt;

  // Count consecutive idle cycles while a frame is open; any accepted byte
  // or a return to IDLE restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state_nxt == IDLE || din_valid) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 16'd1;
    end
  end

  // Expiry only on an idle cycle: a byte arriving on the last allowed cycle
  // is processed normally instead.
  assign timeout_hit = (state != IDLE) && !din_valid && (gap_cnt == GAP_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    buf_we         = 1'b0;
    dout_ld        = 1'b0;
    dout_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Anything other than HEADER, FOOTER included, is dropped silently.
        if (din_valid && din == HEADER) begin
          state_nxt = RECV_DATA;
          cnt_nxt   = '0;
        end
      end
      RECV_DATA: begin
        // HEADER/FOOTER values are ordinary payload here; no resync.
        if (din_valid) begin
          buf_we  = 1'b1;
          cnt_nxt = cnt + 6'd1;
          if (cnt == LAST_IDX) begin
            state_nxt = CHECK_FOOTER;
          end
        end
      end
      CHECK_FOOTER: begin
        // The byte in this slot is consumed either way; a wrong footer is
        // not re-examined as a HEADER.
        if (din_valid) begin
          state_nxt = IDLE;
          if (din == FOOTER) begin
            dout_ld        = 1'b1;
            dout_valid_nxt = 1'b1;
          end else begin
            frame_err_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (timeout_hit) begin
      state_nxt     = IDLE;
      buf_we        = 1'b0;
      frame_err_nxt = 1'b1;
    end
  end

  // Capture payload bytes into their channel slot as they arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer <= '0;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (buf_we && cnt == 6'(k)) begin
          buffer[DATA_W*k +: DATA_W] <= din;
        end
      end
    end
  end

  // Publish a completed frame and register the status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (dout_ld) begin
        dout <= buffer;
      end
      dout_valid <= dout_valid_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed bench for the framed-byte deserializer
// (AA, 16 data bytes, FF) with hand-computed expected frames.
module tb_deserializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   din;
  logic         din_valid;
  logic [127:0] dout;
  logic         dout_valid;
  logic         frame_err;
  logic         busy;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int last_vld_cyc = 0;
  int prev_vld_cyc = 0;
  int foot_cyc = 0;
  int v0;
  int e0;

  deserializer #(
    .HEADER(8'hAA),
    .FOOTER(8'hFF),
    .NUM_CHANNELS(16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .dout(dout),
    .dout_valid(dout_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (dout_valid) begin
      vld_cnt      <= vld_cnt + 1;
      prev_vld_cyc <= last_vld_cyc;
      last_vld_cyc <= cyc;
      check("valid_err_exclusive", 128'(frame_err), 128'd0);
    end
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    din       = b;
    din_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      din_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] step,
                            input logic [7:0] ftr, input bit gapped);
    send(8'hAA);
    if (gapped) idle(2);
    for (int k = 0; k < 16; k++) begin
      send(base + step * 8'(k));
      if (gapped) idle(((k * 3) % 10) + 1);
    end
    send(ftr);
    foot_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #2;
    check("rst_dout", dout, 128'd0);
    check("rst_valid", 128'(dout_valid), 128'd0);
    check("rst_err", 128'(frame_err), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // 1: contiguous frame 00..0F
    v0 = vld_cnt;
    send(8'hAA);
    idle(1);
    check("t1_busy_mid", 128'(busy), 128'd1);
    for (int k = 0; k < 16; k++) send(8'(k));
    send(8'hFF);
    foot_cyc = cyc;
    idle(1);
    check("t1_valid", 128'(dout_valid), 128'd1);
    check("t1_err", 128'(frame_err), 128'd0);
    check("t1_dout", dout, 128'h0F0E0D0C0B0A09080706050403020100);
    check("t1_busy_end", 128'(busy), 128'd0);
    idle(1);
    check("t1_valid_one_cycle", 128'(dout_valid), 128'd0);
    check("t1_latency", 128'(last_vld_cyc), 128'(foot_cyc + 1));
    check("t1_pulses", 128'(vld_cnt - v0), 128'd1);

    // 2: bytes 11..20 with idle gaps
    send_frame(8'h11, 8'h01, 8'hFF, 1'b1);
    idle(1);
    check("t2_valid", 128'(dout_valid), 128'd1);
    check("t2_dout", dout, 128'h201F1E1D1C1B1A191817161514131211);
    idle(1);
    check("t2_latency", 128'(last_vld_cyc), 128'(foot_cyc + 1));

    // 3: bad footer keeps previous frame, next frame accepted
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame(8'h30, 8'h01, 8'h55, 1'b0);
    idle(1);
    check("t3_err", 128'(frame_err), 128'd1);
    check("t3_valid", 128'(dout_valid), 128'd0);
    check("t3_dout_kept", dout, 128'h201F1E1D1C1B1A191817161514131211);
    idle(1);
    check("t3_err_one_cycle", 128'(frame_err), 128'd0);
    send_frame(8'h40, 8'h01, 8'hFF, 1'b0);
    idle(2);
    check("t3_recover_dout", dout, 128'h4F4E4D4C4B4A49484746454443424140);
    check("t3_pulses", 128'(vld_cnt - v0), 128'd1);
    check("t3_errs", 128'(err_cnt - e0), 128'd1);

    // 4: garbage ignored, payload of HEADER values
    e0 = err_cnt;
    send(8'h12);
    send(8'hFF);
    send(8'h34);
    idle(1);
    check("t4_garbage_busy", 128'(busy), 128'd0);
    send_frame(8'hAA, 8'h00, 8'hFF, 1'b0);
    idle(2);
    check("t4_dout", dout, {16{8'hAA}});
    check("t4_errs", 128'(err_cnt - e0), 128'd0);

    // 5: two frames with zero gap
    v0 = vld_cnt;
    send_frame(8'h50, 8'h01, 8'hFF, 1'b0);
    send_frame(8'h60, 8'h01, 8'hFF, 1'b0);
    idle(2);
    check("t5_pulses", 128'(vld_cnt - v0), 128'd2);
    check("t5_spacing", 128'(last_vld_cyc - prev_vld_cyc), 128'd18);
    check("t5_dout", dout, 128'h6F6E6D6C6B6A69686766656463626160);

    // 6: reset mid-frame, then a full frame
    v0 = vld_cnt;
    e0 = err_cnt;
    send(8'hAA);
    for (int k = 0; k < 8; k++) send(8'h90 + 8'(k));
    #1 rst = 1'b1;
    #1;
    check("t6_rst_busy", 128'(busy), 128'd0);
    check("t6_rst_dout", dout, 128'd0);
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    check("t6_no_pulse", 128'(vld_cnt - v0), 128'd0);
    check("t6_no_err", 128'(err_cnt - e0), 128'd0);
    send_frame(8'h70, 8'h01, 8'hFF, 1'b0);
    idle(1);
    check("t6_valid", 128'(dout_valid), 128'd1);
    check("t6_dout", dout, 128'h7F7E7D7C7B7A79787776757473727170);

`ifdef DESER_TIMEOUT_EN
    // stalled frame aborts after the idle limit
    e0 = err_cnt;
    send(8'hAA);
    send(8'h01);
    send(8'h02);
    idle(66);
    check("t6_timeout_err", 128'(err_cnt - e0), 128'd1);
    check("t6_timeout_busy", 128'(busy), 128'd0);
    check("t6_timeout_dout", dout, 128'h7F7E7D7C7B7A79787776757473727170);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
